// File: rtl/config_manager_param_pkg.sv
// ----------------------------------------------------------------------------
// config_pkg
// Shared definitions for the framed configuration manager: the frame header
// byte, the error codes reported on erro_codigo and the receive FSM encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package config_pkg;

    // First byte of every configuration frame.
    localparam logic [7:0] CAB_CONFIG = 8'hA5;

    // Error codes, held on erro_codigo until the next rejected frame.
    typedef enum logic [1:0] {
        ERR_TIMEOUT  = 2'd0,
        ERR_PARIDADE = 2'd1,
        ERR_INDICE   = 2'd2,
        ERR_CHECKSUM = 2'd3
    } erro_e;

    // Receive FSM states.
    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ESPERA_CAB  = 3'd1,
        RECEBE_IDX  = 3'd2,
        RECEBE_DADO = 3'd3,
        RECEBE_CHK  = 3'd4,
        COMMIT      = 3'd5,
        ERRO        = 3'd6
    } estado_e;

endpackage

// File: rtl/config_manager_param_contador_timeout.sv
// ----------------------------------------------------------------------------
// contador_timeout
// Inter-byte idle counter. Counts clock cycles while 'conta' is high and
// saturates at TIMEOUT_CYCLES-1, where 'fim' is raised. 'zera' has priority
// and returns the count to zero.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   zera   in   synchronous clear
//   conta  in   count enable
//   fim    out  count has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_cnt;

    assign fim = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Idle cycle counter; holds at the limit so 'fim' stays asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (zera) begin
            r_cnt <= '0;
        end else if (conta && !fim) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/config_manager_param.sv
// ----------------------------------------------------------------------------
// config_manager_param
// Receives framed configuration writes (A5, index, data MSB first, XOR
// checksum) from a UART byte receiver and commits the value to one of NUM_CH
// limit registers only after the whole frame has validated.
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   receber_config  in   one-cycle pulse arming reception of one frame
//   rx_dado         in   received byte
//   rx_pronto       in   rx_dado valid strobe
//   rx_paridade_ok  in   parity status of rx_dado (qualified by rx_pronto)
//   lim_out         out  flat limit bus, channel k at [k*WIDTH +: WIDTH]
//   pronto_config   out  one-cycle pulse: frame committed
//   erro_config     out  one-cycle pulse: frame rejected
//   erro_codigo     out  last error code (held)
//   ocupado         out  high from arming until commit or rejection
// ----------------------------------------------------------------------------
module config_manager_param
    import config_pkg::*;
#(
    parameter int               NUM_CH         = 5,
    parameter int               WIDTH          = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int               TIMEOUT_CYCLES = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    receber_config,
    input  logic [7:0]              rx_dado,
    input  logic                    rx_pronto,
    input  logic                    rx_paridade_ok,
    output logic [NUM_CH*WIDTH-1:0] lim_out,
    output logic                    pronto_config,
    output logic                    erro_config,
    output logic [1:0]              erro_codigo,
    output logic                    ocupado
);

    localparam int NBYTES = (WIDTH + 7) / 8;
    localparam int SW     = NBYTES * 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    estado_e                 r_estado;
    logic [7:0]              r_idx;
    logic [7:0]              r_chk;
    logic [SW-1:0]           r_shadow;
    logic [BCW-1:0]          r_nbyte;
    logic                    r_pronto;
    logic                    r_erro;
    logic [1:0]              r_codigo;
    logic                    r_ocupado;
    logic [NUM_CH*WIDTH-1:0] r_lim;

    logic                    w_conta;
    logic                    w_zera;
    logic                    w_fim;
    logic                    w_falha;
    erro_e                   w_codigo;
    logic [SW-1:0]           w_shadow_prox;

    // The timeout only runs while a frame is in flight (after the header).
    assign w_conta       = (r_estado == RECEBE_IDX) || (r_estado == RECEBE_DADO) ||
                           (r_estado == RECEBE_CHK);
    assign w_zera        = rx_pronto || !w_conta;
    assign w_shadow_prox = (r_shadow << 8) | SW'(rx_dado);

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock(clock),
        .reset(reset),
        .zera (w_zera),
        .conta(w_conta),
        .fim  (w_fim)
    );

    // Frame rejection decode: a strobed byte beats the timeout; the index check beats the checksum check.
    always_comb begin
        w_falha  = 1'b0;
        w_codigo = ERR_TIMEOUT;
        if (w_conta) begin
            if (rx_pronto) begin
                if (!rx_paridade_ok) begin
                    w_falha  = 1'b1;
                    w_codigo = ERR_PARIDADE;
                end else if (r_estado == RECEBE_CHK) begin
                    if (r_idx >= 8'(NUM_CH)) begin
                        w_falha  = 1'b1;
                        w_codigo = ERR_INDICE;
                    end else if (rx_dado != r_chk) begin
                        w_falha  = 1'b1;
                        w_codigo = ERR_CHECKSUM;
                    end else begin
                        w_falha = 1'b0;
                    end
                end else begin
                    w_falha = 1'b0;
                end
            end else if (w_fim) begin
                w_falha  = 1'b1;
                w_codigo = ERR_TIMEOUT;
            end else begin
                w_falha = 1'b0;
            end
        end else begin
            w_falha = 1'b0;
        end
    end

    // Receive FSM with registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= OCIOSO;
            r_idx     <= 8'h00;
            r_chk     <= 8'h00;
            r_shadow  <= '0;
            r_nbyte   <= '0;
            r_pronto  <= 1'b0;
            r_erro    <= 1'b0;
            r_codigo  <= 2'd0;
            r_ocupado <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            r_erro   <= 1'b0;
            if (w_falha) begin
                // ERRO state itself is the cycle the pulse is visible.
                r_estado  <= ERRO;
                r_erro    <= 1'b1;
                r_codigo  <= w_codigo;
                r_ocupado <= 1'b0;
            end else begin
                case (r_estado)
                    OCIOSO: begin
                        if (receber_config) begin
                            r_estado  <= ESPERA_CAB;
                            r_ocupado <= 1'b1;
                        end else begin
                            r_estado <= OCIOSO;
                        end
                    end
                    ESPERA_CAB: begin
                        if (rx_pronto && rx_paridade_ok && (rx_dado == CAB_CONFIG)) begin
                            r_estado <= RECEBE_IDX;
                        end else begin
                            r_estado <= ESPERA_CAB;
                        end
                    end
                    RECEBE_IDX: begin
                        if (rx_pronto) begin
                            r_idx    <= rx_dado;
                            r_chk    <= rx_dado;
                            r_shadow <= '0;
                            r_nbyte  <= '0;
                            r_estado <= RECEBE_DADO;
                        end else begin
                            r_estado <= RECEBE_IDX;
                        end
                    end
                    RECEBE_DADO: begin
                        if (rx_pronto) begin
                            r_shadow <= w_shadow_prox;
                            r_chk    <= r_chk ^ rx_dado;
                            if (r_nbyte == BCW'(NBYTES - 1)) begin
                                r_estado <= RECEBE_CHK;
                            end else begin
                                r_nbyte <= r_nbyte + 1'b1;
                            end
                        end else begin
                            r_estado <= RECEBE_DADO;
                        end
                    end
                    RECEBE_CHK: begin
                        if (rx_pronto) begin
                            r_estado <= COMMIT;
                        end else begin
                            r_estado <= RECEBE_CHK;
                        end
                    end
                    COMMIT: begin
                        r_pronto  <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                    ERRO: begin
                        r_estado <= OCIOSO;
                    end
                    default: begin
                        r_estado  <= OCIOSO;
                        r_ocupado <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Limit bank: only the validated channel is written, and only in COMMIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lim <= {NUM_CH{RESET_VALUE}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ((r_estado == COMMIT) && (r_idx == 8'(k))) begin
                    r_lim[k*WIDTH +: WIDTH] <= r_shadow[WIDTH-1:0];
                end else begin
                    r_lim[k*WIDTH +: WIDTH] <= r_lim[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign lim_out       = r_lim;
    assign pronto_config = r_pronto;
    assign erro_config   = r_erro;
    assign erro_codigo   = r_codigo;
    assign ocupado       = r_ocupado;

endmodule

// File: tb/tb_config_manager_param.sv
// ----------------------------------------------------------------------------
// tb_config_manager_param
// Directed bench for config_manager_param (NUM_CH=5, WIDTH=16,
// TIMEOUT_CYCLES=100): a table of whole frames with hand-computed results,
// followed by hand-written timeout, parity and mid-frame reset sequences.
// ----------------------------------------------------------------------------
module tb_config_manager_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        receber_config = 1'b0;
    logic [7:0]  rx_dado = 8'h00;
    logic        rx_pronto = 1'b0;
    logic        rx_paridade_ok = 1'b1;
    logic [79:0] lim_out;
    logic        pronto_config;
    logic        erro_config;
    logic [1:0]  erro_codigo;
    logic        ocupado;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_lim [5];

    typedef struct {
        logic        arm;
        int          nb;
        logic [47:0] bytes;
        logic [5:0]  par;
        int          exp_ok;
        int          exp_err;
        logic [1:0]  exp_code;
        int          wr_ch;
        logic [15:0] wr_val;
    } vec_t;

    vec_t tab [8];

    config_manager_param #(
        .NUM_CH(5),
        .WIDTH(16),
        .RESET_VALUE(16'h0000),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .receber_config(receber_config),
        .rx_dado(rx_dado),
        .rx_pronto(rx_pronto),
        .rx_paridade_ok(rx_paridade_ok),
        .lim_out(lim_out),
        .pronto_config(pronto_config),
        .erro_config(erro_config),
        .erro_codigo(erro_codigo),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] lim_ch(input int k);
        return lim_out[k*16 +: 16];
    endfunction

    function automatic logic [7:0] byte_of(input logic [47:0] bs, input int i);
        return bs[47-8*i -: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic arm();
        @(negedge clock);
        receber_config = 1'b1;
        @(negedge clock);
        receber_config = 1'b0;
    endtask

    // Returns on the falling edge right after the rising edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b, input logic par);
        @(negedge clock);
        rx_dado        = b;
        rx_paridade_ok = par;
        rx_pronto      = 1'b1;
        @(negedge clock);
        rx_pronto      = 1'b0;
        rx_paridade_ok = 1'b1;
    endtask

    task automatic check_all_lims(input string tag);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_lim%0d", tag, k), lim_ch(k), exp_lim[k]);
        end
    endtask

    initial begin
        int n_ok;
        int n_err;
        int early;
        logic [1:0] code;

        for (int k = 0; k < 5; k++) exp_lim[k] = 16'h0000;

        //          arm   nb  bytes (left-justified)  parity     ok err code ch  value
        tab[0] = '{1'b1, 5, 48'hA5_02_01_F4_F7_00, 6'b111111, 1, 0, 2'd0, 2, 16'h01F4};
        tab[1] = '{1'b1, 5, 48'hA5_02_01_F4_F6_00, 6'b111111, 0, 1, 2'd3, -1, 16'h0000};
        tab[2] = '{1'b1, 5, 48'hA5_05_00_10_15_00, 6'b111111, 0, 1, 2'd2, -1, 16'h0000};
        tab[3] = '{1'b0, 5, 48'hA5_00_12_34_26_00, 6'b111111, 0, 0, 2'd0, -1, 16'h0000};
        tab[4] = '{1'b1, 6, 48'h33_A5_00_12_34_26, 6'b111111, 1, 0, 2'd0, 0, 16'h1234};
        tab[5] = '{1'b1, 5, 48'hA5_04_FF_FF_04_00, 6'b111111, 1, 0, 2'd0, 4, 16'hFFFF};
        tab[6] = '{1'b1, 5, 48'hA5_03_AB_CD_65_00, 6'b111111, 1, 0, 2'd0, 3, 16'hABCD};
        tab[7] = '{1'b1, 6, 48'hA5_A5_01_00_2A_2B, 6'b111110, 1, 0, 2'd0, 1, 16'h002A};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_pronto", pronto_config, 1'b0);
        check("rst_erro", erro_config, 1'b0);
        check("rst_codigo", erro_codigo, 2'd0);
        check("rst_ocupado", ocupado, 1'b0);
        check_all_lims("rst");

        // Table of whole frames
        for (int v = 0; v < 8; v++) begin
            if (tab[v].arm) begin
                arm();
                check($sformatf("v%0d_ocupado_armed", v), ocupado, 1'b1);
            end
            for (int i = 0; i < tab[v].nb; i++) begin
                send_byte(byte_of(tab[v].bytes, i), tab[v].par[i]);
            end
            n_ok  = 0;
            n_err = 0;
            code  = 2'd0;
            for (int c = 0; c < 6; c++) begin
                if (c == 0 && tab[v].exp_ok == 1) begin
                    check($sformatf("v%0d_lim_latency", v), lim_ch(tab[v].wr_ch), exp_lim[tab[v].wr_ch]);
                    check($sformatf("v%0d_ocupado_commit", v), ocupado, 1'b1);
                end
                if (pronto_config) begin
                    n_ok++;
                    check($sformatf("v%0d_ocupado_ok", v), ocupado, 1'b0);
                end
                if (erro_config) begin
                    n_err++;
                    code = erro_codigo;
                    check($sformatf("v%0d_ocupado_err", v), ocupado, 1'b0);
                end
                @(negedge clock);
            end
            check($sformatf("v%0d_pronto_pulses", v), n_ok, tab[v].exp_ok);
            check($sformatf("v%0d_erro_pulses", v), n_err, tab[v].exp_err);
            if (tab[v].exp_err == 1) begin
                check($sformatf("v%0d_codigo", v), code, tab[v].exp_code);
            end
            if (tab[v].wr_ch >= 0) exp_lim[tab[v].wr_ch] = tab[v].wr_val;
            check_all_lims($sformatf("v%0d", v));
        end

        // Timeout: error visible exactly 100 cycles after the index strobe
        arm();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        early = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k < 100 && erro_config) early++;
        end
        check("to_early", early, 0);
        check("to_fire", erro_config, 1'b1);
        check("to_code", erro_codigo, 2'd0);
        check("to_ocupado", ocupado, 1'b0);
        @(negedge clock);
        check("to_pulse_width", erro_config, 1'b0);
        check_all_lims("to");

        // A byte strobed on the timeout cycle wins and restarts the count
        arm();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        early = 0;
        for (int k = 0; k < 98; k++) begin
            @(negedge clock);
            if (erro_config) early++;
        end
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (erro_config) early++;
        end
        check("win_no_err", early, 0);
        check("win_ocupado", ocupado, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h11, 1'b1);
        @(negedge clock);
        check("win_pronto", pronto_config, 1'b1);
        exp_lim[1] = 16'h0010;
        check_all_lims("win");

        // Parity failure on the index byte
        arm();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b0);
        check("par_erro", erro_config, 1'b1);
        check("par_code", erro_codigo, 2'd1);
        check("par_ocupado", ocupado, 1'b0);
        repeat (2) @(negedge clock);
        check_all_lims("par");

        // Reset in the middle of a frame
        arm();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h12, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) exp_lim[k] = 16'h0000;
        check_all_lims("mid_rst");
        check("mid_rst_ocupado", ocupado, 1'b0);
        check("mid_rst_codigo", erro_codigo, 2'd0);
        @(negedge clock);
        reset = 1'b1;
        send_byte(8'h34, 1'b1);
        send_byte(8'h25, 1'b1);
        n_ok  = 0;
        n_err = 0;
        for (int c = 0; c < 5; c++) begin
            if (pronto_config) n_ok++;
            if (erro_config) n_err++;
            @(negedge clock);
        end
        check("mid_rst_no_pronto", n_ok, 0);
        check("mid_rst_no_erro", n_err, 0);
        check("mid_rst_ocupado_after", ocupado, 1'b0);
        check_all_lims("mid_rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_manager_param.md
Name: config_manager_param

Overview:
- Parametrised successor to the fixed five-limit configuration manager.
- Accepts framed configuration writes from the existing UART byte receiver and updates one of NUM_CH limit registers, each WIDTH bits wide.
- Each frame is checked for byte parity, channel index and XOR checksum. An inter-byte timeout is enforced.
- A limit register is written only after the whole frame validates, so the register is either fully updated or left unchanged. The outputs feed the threshold comparators.

Parameters:
- NUM_CH, 5: number of limit channels (1..16).
- WIDTH, 16: bits per limit (8..32). Localparam NBYTES = ceil(WIDTH/8).
- RESET_VALUE, 0: value loaded into every limit on reset.
- TIMEOUT_CYCLES, 50000: maximum idle clock cycles between bytes inside a frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- receber_config  in  1  one-cycle pulse; arms reception of one frame.
- rx_dado  in  8  received byte.
- rx_pronto  in  1  one-cycle strobe: rx_dado is valid.
- rx_paridade_ok  in  1  parity status of rx_dado; qualified by rx_pronto.
- lim_out  out  NUM_CH*WIDTH  flat limit bus; channel k occupies bits [k*WIDTH +: WIDTH].
- pronto_config  out  1  one-cycle pulse: frame committed.
- erro_config  out  1  one-cycle pulse: frame rejected.
- erro_codigo  out  2  0 timeout, 1 parity, 2 bad index, 3 checksum. Held until the next error.
- ocupado  out  1  high from arming until pronto_config or erro_config.

Behaviour:
- Reset (async, reset=0):
  - All limits = RESET_VALUE.
  - pronto_config = 0, erro_config = 0, erro_codigo = 0, ocupado = 0.
  - State = OCIOSO; timeout counter and checksum accumulator cleared.
  - A reset mid-frame discards the partial frame; the limits still return to RESET_VALUE.
- Frame format: 0xA5 header, index byte, NBYTES data bytes MSB first, checksum byte.
  - Checksum = XOR of the index byte and all data bytes.
  - The assembled value is truncated to its low WIDTH bits; padding bits above WIDTH are ignored.
- FSM states and transitions:
  - OCIOSO: receber_config -> ESPERA_CAB, ocupado=1. rx_pronto bytes are ignored.
  - ESPERA_CAB: a byte equal to 0xA5 with good parity -> RECEBE_IDX. Any other byte, or a parity-bad byte, is discarded silently. No timeout applies in this state.
  - RECEBE_IDX: stores the index and seeds the checksum accumulator with it -> RECEBE_DADO, byte counter = 0.
  - RECEBE_DADO: shifts the byte into the shadow register and XORs it into the accumulator. After byte NBYTES-1 -> RECEBE_CHK.
  - RECEBE_CHK: goes to COMMIT if index < NUM_CH and the byte equals the accumulator.
    - Index >= NUM_CH -> ERRO, code 2 (the index check has priority over the checksum check).
    - Checksum mismatch -> ERRO, code 3.
  - COMMIT (1 cycle): lim_out[idx] <= shadow; pronto_config=1; ocupado=0 -> OCIOSO. Latency: lim_out changes on the edge one cycle after the checksum strobe.
  - ERRO (1 cycle): erro_config=1, erro_codigo updated, ocupado=0 -> OCIOSO. No limit is modified.
- Parity: rx_pronto with rx_paridade_ok=0 in RECEBE_IDX, RECEBE_DADO or RECEBE_CHK -> ERRO, code 1.
- Timeout:
  - The counter runs in RECEBE_IDX, RECEBE_DADO and RECEBE_CHK and clears on every rx_pronto.
  - When the count reaches TIMEOUT_CYCLES-1 -> ERRO, code 0.
  - If rx_pronto arrives in the same cycle as the timeout, the byte wins and the counter clears.
- receber_config while ocupado=1 is ignored.
- receber_config in the same cycle as a COMMIT or ERRO cycle is ignored; the source must re-pulse.
- Only one frame is accepted per arming.

Decomposition:
- Package config_pkg holds:
  - CAB_CONFIG = 8'hA5.
  - Error codes ERR_TIMEOUT / ERR_PARIDADE / ERR_INDICE / ERR_CHECKSUM.
  - The FSM state encoding.
- Sub-module contador_timeout: parameter TIMEOUT_CYCLES; ports clock, reset, zera, conta, fim.
- The FSM, shadow register, checksum accumulator and limit bank stay in the top level.

Test Plan (NUM_CH=5, WIDTH=16, TIMEOUT_CYCLES=100):
- Reset released, then arm and send A5 02 01 F4 F7 -> one pronto_config pulse; lim[2]=0x01F4; other channels stay 0; ocupado drops together with the pulse.
- Arm and send A5 02 01 F4 F6 -> erro_config pulse, erro_codigo=3, lim[2] unchanged.
- Arm and send A5 05 00 10 15 -> erro_codigo=2; no channel written.
- Arm, send A5 01, then stay silent -> erro_config exactly 100 cycles after the 01 strobe, code 0. A byte strobed on cycle 99 instead restarts the count and no error occurs.
- Not armed, send A5 00 12 34 26 -> no pulses, lim[0] unchanged. Arm, send 33 A5 00 12 34 26 -> leading 33 discarded, lim[0]=0x1234.
- Mid-frame after A5 03 12: assert reset low for 1 cycle -> all limits 0, ocupado=0. Send the remaining bytes -> ignored.
- Parity: arm, send A5 then 03 with rx_paridade_ok=0 -> erro_codigo=1.
